// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator datapath blocks (multiplier, divider).
//   ANCHO_CALC      default operand width used by the arithmetic units.
//   mult_estados_t  state encoding of the shift-add multiplier FSM.
//   mult_iter_bits  width of a counter able to hold the value "ancho".
// -----------------------------------------------------------------------------
package calc_pkg;

    localparam int ANCHO_CALC = 16;

    typedef enum logic [2:0] {
        REPOSO    = 3'd0,
        CARGA     = 3'd1,
        SUMAR     = 3'd2,
        DESPLAZAR = 3'd3,
        FIN       = 3'd4
    } mult_estados_t;

    function automatic int mult_iter_bits(input int ancho);
        return $clog2(ancho + 1);
    endfunction

endpackage

// File: rtl/multiplicador_if.sv
// -----------------------------------------------------------------------------
// multiplicador_if
// iniciar/terminado handshake plus operand/result bus of the multiplier.
//   iniciar        start request from the sequencer
//   multiplicando  operand A (ANCHO bits)
//   multiplicador  operand B (ANCHO bits)
//   producto       2*ANCHO-bit registered result
//   terminado      one-cycle done pulse
//   ocupado        block busy (not idle)
// Modports: master = operation sequencer, slave = multiplier.
// -----------------------------------------------------------------------------
interface multiplicador_if
    import calc_pkg::*;
#(
    parameter int ANCHO = ANCHO_CALC
) ();

    logic                   iniciar;
    logic [ANCHO-1:0]       multiplicando;
    logic [ANCHO-1:0]       multiplicador;
    logic [2*ANCHO-1:0]     producto;
    logic                   terminado;
    logic                   ocupado;

    modport master (
        output iniciar,
        output multiplicando,
        output multiplicador,
        input  producto,
        input  terminado,
        input  ocupado
    );

    modport slave (
        input  iniciar,
        input  multiplicando,
        input  multiplicador,
        output producto,
        output terminado,
        output ocupado
    );

endinterface

// File: rtl/multiplicador.sv
// -----------------------------------------------------------------------------
// multiplicador
// Sequential unsigned shift-add multiplier. One multiplier bit is consumed
// every two clocks (SUMAR then DESPLAZAR); the 2*ANCHO-bit product is
// published in FIN together with a one-cycle terminado pulse.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  multiplicador_if.slave : iniciar, multiplicando, multiplicador (in)
//                                 producto, terminado, ocupado (out)
//
// Optional build macro MULT_ZERO_BYPASS_EN: when defined, a zero operand
// seen in CARGA jumps straight to FIN with a zero accumulator. The result is
// the same either way; only the latency shortens.
// -----------------------------------------------------------------------------
module multiplicador
    import calc_pkg::*;
#(
    parameter int ANCHO = ANCHO_CALC
) (
    input  logic            clk,
    input  logic            rst,
    multiplicador_if.slave  bus
);

    localparam int IW = mult_iter_bits(ANCHO);

    mult_estados_t          state_reg;
    mult_estados_t          state_next;

    // acc = {carry, hi, lo}; lo starts as the multiplier and is shifted out
    // while the product grows into hi/lo from the top.
    logic [2*ANCHO:0]       acc_reg;
    logic [ANCHO-1:0]       mcand_reg;
    logic [IW-1:0]          iter_reg;
    logic [2*ANCHO-1:0]     producto_reg;
    logic                   terminado_reg;
    logic                   operando_cero;

`ifdef MULT_ZERO_BYPASS_EN
    assign operando_cero = (bus.multiplicando == '0) || (bus.multiplicador == '0);
`else
    assign operando_cero = 1'b0;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= REPOSO;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            REPOSO:    if (bus.iniciar) state_next = CARGA;
            CARGA:     state_next = operando_cero ? FIN : SUMAR;
            SUMAR:     state_next = DESPLAZAR;
            DESPLAZAR: state_next = (iter_reg == IW'(1)) ? FIN : SUMAR;
            FIN:       state_next = REPOSO;
            default:   state_next = REPOSO;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg       <= '0;
            mcand_reg     <= '0;
            iter_reg      <= '0;
            producto_reg  <= '0;
            terminado_reg <= 1'b0;
        end else begin
            // terminado is only ever high in the cycle following FIN
            terminado_reg <= (state_reg == FIN);
            case (state_reg)
                CARGA: begin
                    if (operando_cero) begin
                        acc_reg <= '0;
                    end else begin
                        acc_reg <= {1'b0, {ANCHO{1'b0}}, bus.multiplicador};
                    end
                    mcand_reg <= bus.multiplicando;
                    iter_reg  <= IW'(ANCHO);
                end
                SUMAR: begin
                    // The carry bit is always zero here (cleared by the
                    // previous shift), so the (ANCHO+1)-bit sum cannot wrap.
                    if (acc_reg[0]) begin
                        acc_reg[2*ANCHO:ANCHO] <= {1'b0, acc_reg[2*ANCHO-1:ANCHO]}
                                                + {1'b0, mcand_reg};
                    end
                end
                DESPLAZAR: begin
                    acc_reg  <= acc_reg >> 1;
                    iter_reg <= iter_reg - IW'(1);
                end
                FIN: begin
                    producto_reg <= acc_reg[2*ANCHO-1:0];
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.producto  = producto_reg;
    assign bus.terminado = terminado_reg;
    assign bus.ocupado   = (state_reg != REPOSO);

endmodule

// File: tb/tb_multiplicador.sv
// -----------------------------------------------------------------------------
// tb_multiplicador
// Scoreboard bench for multiplicador. A start tracker models when a request
// is accepted (idle block + iniciar), records the operands present at the
// capture edge and pushes the expected product and completion edge. A
// monitor pops on every terminado and also checks that producto holds
// between pulses. Build with +define+MULT_ZERO_BYPASS_EN to expect the
// short zero-operand latency.
// -----------------------------------------------------------------------------
module tb_multiplicador;

    localparam int W = 16;
`ifdef MULT_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multiplicador_if #(.ANCHO(W)) bus ();

    multiplicador #(.ANCHO(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        longint unsigned prod;
        int              done;
        int unsigned     a;
        int unsigned     b;
    } exp_t;

    exp_t            exp_q[$];
    int              checks    = 0;
    int              errors    = 0;
    int              cyc       = 0;
    bit              busy      = 1'b0;
    bit              cap_pending = 1'b0;
    int              start_edge = 0;
    int              done_edge  = 0;
    int              n_done    = 0;
    logic [2*W-1:0]  last_prod = '0;

    function automatic void check(input string name, input longint unsigned act,
                                  input longint unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // ---------------- start tracker (reference model) ----------------
    always @(posedge clk) begin : tracker
        int unsigned a;
        int unsigned b;
        exp_t        e;
        cyc = cyc + 1;
        if (rst) begin
            busy        = 1'b0;
            cap_pending = 1'b0;
            exp_q.delete();
        end else begin
            if (cap_pending) begin
                a      = int'(bus.multiplicando);
                b      = int'(bus.multiplicador);
                e.a    = a;
                e.b    = b;
                e.prod = longint'(a) * longint'(b);
                e.done = start_edge + ((BYPASS && (a == 0 || b == 0)) ? 2 : 2 * W + 2);
                done_edge = e.done;
                exp_q.push_back(e);
                cap_pending = 1'b0;
            end
            if (busy && !cap_pending && cyc > done_edge) busy = 1'b0;
            if (!busy && bus.iniciar) begin
                busy        = 1'b1;
                cap_pending = 1'b1;
                start_edge  = cyc;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            last_prod = '0;
        end else if (bus.terminado) begin
            n_done++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_terminado: got producto=0x%0h, required no pulse (cycle %0d)",
                         bus.producto, cyc);
            end else begin
                e = exp_q.pop_front();
                $display("op %0d x %0d -> 0x%0h (expected 0x%0h) at edge %0d", e.a, e.b,
                         bus.producto, e.prod, cyc);
                check("producto", bus.producto, e.prod);
                check("latencia", longint'(cyc), longint'(e.done));
            end
            last_prod = bus.producto;
        end else begin
            check("producto_estable", bus.producto, last_prod);
            if (exp_q.size() > 0 && cyc > exp_q[0].done) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_terminado: got none by edge %0d, required at edge %0d (%0d x %0d)",
                         cyc, e.done, e.a, e.b);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.multiplicando = a;
        bus.multiplicador = b;
        bus.iniciar       = 1'b1;
        @(negedge clk);
        bus.iniciar       = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        @(negedge clk);
        while ((busy || cap_pending || exp_q.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy || cap_pending || exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got block still pending after %0d cycles, required idle", budget);
        end
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no end of run, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int target;
        logic [W-1:0] ra, rb;
        bus.iniciar       = 1'b0;
        bus.multiplicando = '0;
        bus.multiplicador = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("reset_producto", bus.producto, 0);
        check("reset_terminado", bus.terminado, 0);
        check("reset_ocupado", bus.ocupado, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // basic 3 x 5 with ocupado profile: high after edges 0..33, low after 34
        start_op(16'd3, 16'd5);
        check("ocupado_k0", bus.ocupado, 1);
        for (int k = 1; k <= 2 * W + 2; k++) begin
            @(negedge clk);
            check("ocupado_perfil", bus.ocupado, (k <= 2 * W + 1) ? 1 : 0);
        end
        wait_done(100);

        // carry paths and zero operands
        start_op(16'hFFFF, 16'hFFFF); wait_done(100);
        start_op(16'h8000, 16'h0002); wait_done(100);
        start_op(16'h0000, 16'h1234); wait_done(100);
        start_op(16'h1234, 16'h0000); wait_done(100);

        // busy: second request at edge 10 with new operands is ignored
        start_op(16'd7, 16'd9);
        repeat (9) @(negedge clk);
        bus.multiplicando = 16'd2;
        bus.multiplicador = 16'd2;
        bus.iniciar       = 1'b1;
        @(negedge clk);
        bus.iniciar       = 1'b0;
        wait_done(100);
        repeat (40) @(negedge clk);

        // iniciar held high: back-to-back operations every 2*W+3 cycles
        target = n_done + 2;
        bus.iniciar = 1'b1;
        for (int n = 0; n < 200 && n_done < target; n++) @(negedge clk);
        bus.iniciar = 1'b0;
        check("repeticion_pulsos", (n_done >= target) ? 1 : 0, 1);
        wait_done(100);

        // asynchronous reset mid-operation
        start_op(16'd100, 16'd200);
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_producto", bus.producto, 0);
        check("rst_async_terminado", bus.terminado, 0);
        check("rst_async_ocupado", bus.ocupado, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        start_op(16'd100, 16'd200); wait_done(100);

        // random pairs; operands scrambled after capture must not matter
        for (int i = 0; i < 1000; i++) begin
            ra = ($urandom_range(7) == 0) ? '0 : W'($urandom);
            rb = ($urandom_range(7) == 0) ? '0 : W'($urandom);
            start_op(ra, rb);
            @(negedge clk);
            bus.multiplicando = W'($urandom);
            bus.multiplicador = W'($urandom);
            wait_done(100);
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
